// File: rtl/zjh_int_ctrl8.sv
// Eight-channel interrupt controller: latches active-low requests, masks them and
// hands the highest-index pending channel to the CPU through a req/ack/eoi handshake.
module zjh_int_ctrl8 #(
   parameter bit EDGE_MODE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_n,
   input  logic [7:0] mask,
   input  logic       en,
   input  logic       int_ack,
   input  logic       eoi,
   output logic       int_req,
   output logic [2:0] int_vec,
   output logic       busy,
   output logic       gs
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] irq_prev;
   logic [7:0] pending;
   logic [7:0] pending_next;
   logic [7:0] set_bits;
   logic [7:0] clr_bits;
   logic [7:0] cand;
   logic [2:0] winner;
   logic       load_vec;
   logic       take_ack;

   always_comb begin
      if (EDGE_MODE)
         set_bits = irq_prev & ~irq_n;
      else
         set_bits = ~irq_n;
   end

   assign cand = pending & ~mask;

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      winner = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (cand[i])
            winner = 3'(i);
      end
   end

   always_comb begin
      state_next = state;
      load_vec   = 1'b0;
      take_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (en && (cand != 8'h00)) begin
               state_next = REQ;
               load_vec   = 1'b1;
            end
         end
         REQ: begin
            if (int_ack) begin
               state_next = SERVICE;
               take_ack   = 1'b1;
            end
         end
         SERVICE: begin
            if (eoi)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A new set on the channel being acknowledged overrides its clear.
   always_comb begin
      clr_bits = 8'h00;
      if (take_ack)
         clr_bits = 8'h01 << int_vec;
      pending_next = (pending & ~clr_bits) | set_bits;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         irq_prev <= 8'hFF;
         pending  <= 8'h00;
         int_vec  <= 3'd0;
         int_req  <= 1'b0;
         busy     <= 1'b0;
         gs       <= 1'b0;
      end else begin
         state    <= state_next;
         irq_prev <= irq_n;
         pending  <= pending_next;
         gs       <= |cand;
         int_req  <= (state_next == REQ);
         busy     <= (state_next == SERVICE);
         if (load_vec)
            int_vec <= winner;
      end
   end

endmodule

// File: tb/tb_zjh_int_ctrl8.sv
// Directed bench for zjh_int_ctrl8: an edge-mode instance carries most checks,
// a level-mode instance sharing the inputs covers the level-specific behaviour.
module tb_zjh_int_ctrl8;

   logic       clk;
   logic       rst;
   logic [7:0] irq_n;
   logic [7:0] mask;
   logic       en;
   logic       int_ack;
   logic       eoi;
   logic       int_req;
   logic [2:0] int_vec;
   logic       busy;
   logic       gs;
   logic       lvl_int_req;
   logic [2:0] lvl_int_vec;
   logic       lvl_busy;
   logic       lvl_gs;

   int total;
   int bad;

   zjh_int_ctrl8 #(.EDGE_MODE(1'b1)) dut (
      .clk(clk), .rst(rst), .irq_n(irq_n), .mask(mask), .en(en),
      .int_ack(int_ack), .eoi(eoi),
      .int_req(int_req), .int_vec(int_vec), .busy(busy), .gs(gs)
   );

   zjh_int_ctrl8 #(.EDGE_MODE(1'b0)) dut_lvl (
      .clk(clk), .rst(rst), .irq_n(irq_n), .mask(mask), .en(en),
      .int_ack(int_ack), .eoi(eoi),
      .int_req(lvl_int_req), .int_vec(lvl_int_vec), .busy(lvl_busy), .gs(lvl_gs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are inspected 1 time unit after each rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1;
      step(1);
      eoi = 1'b0;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      irq_n   = 8'hFF;
      mask    = 8'h00;
      en      = 1'b1;
      int_ack = 1'b0;
      eoi     = 1'b0;
      step(2);
      check_output("rst_req", 8'(int_req), 8'h0);
      check_output("rst_vec", 8'(int_vec), 8'h0);
      check_output("rst_busy", 8'(busy), 8'h0);
      check_output("rst_gs", 8'(gs), 8'h0);
      rst = 1'b0;
      step(2);

      // Single edge on channel 5, held low afterwards.
      irq_n[5] = 1'b0;
      step(1);
      check_output("edge_lat_req", 8'(int_req), 8'h0);
      check_output("edge_lat_gs", 8'(gs), 8'h0);
      step(1);
      check_output("edge_req", 8'(int_req), 8'h1);
      check_output("edge_vec", 8'(int_vec), 8'h5);
      check_output("edge_gs", 8'(gs), 8'h1);
      step(2);
      check_output("edge_hold_req", 8'(int_req), 8'h1);
      pulse_ack();
      check_output("ack_busy", 8'(busy), 8'h1);
      check_output("ack_req", 8'(int_req), 8'h0);
      step(1);
      check_output("ack_gs_clear", 8'(gs), 8'h0);
      pulse_eoi();
      check_output("eoi_busy", 8'(busy), 8'h0);
      step(3);
      check_output("held_low_once", 8'(int_req), 8'h0);
      irq_n = 8'hFF;
      step(1);

      // Priority: channels 0, 2, 6 together.
      irq_n = ~8'h45;
      step(1);
      irq_n = 8'hFF;
      step(1);
      check_output("prio_req1", 8'(int_req), 8'h1);
      check_output("prio_vec1", 8'(int_vec), 8'h6);
      pulse_ack();
      pulse_eoi();
      step(1);
      check_output("prio_req2", 8'(int_req), 8'h1);
      check_output("prio_vec2", 8'(int_vec), 8'h2);
      pulse_ack();
      pulse_eoi();
      step(1);
      check_output("prio_vec3", 8'(int_vec), 8'h0);
      pulse_ack();
      step(1);
      check_output("prio_gs_zero", 8'(gs), 8'h0);
      pulse_eoi();
      step(2);
      check_output("prio_done", 8'(int_req), 8'h0);

      // Mask hides channel 7 until it is cleared during service.
      mask  = 8'h80;
      irq_n = ~8'h88;
      step(1);
      irq_n = 8'hFF;
      step(1);
      check_output("mask_vec", 8'(int_vec), 8'h3);
      pulse_ack();
      mask = 8'h00;
      step(2);
      check_output("mask_frozen_vec", 8'(int_vec), 8'h3);
      check_output("mask_frozen_busy", 8'(busy), 8'h1);
      pulse_eoi();
      step(1);
      check_output("unmask_req", 8'(int_req), 8'h1);
      check_output("unmask_vec", 8'(int_vec), 8'h7);
      pulse_ack();
      pulse_eoi();

      // Enable low blocks the request while gs reports the pending channel.
      en       = 1'b0;
      irq_n[1] = 1'b0;
      step(1);
      irq_n = 8'hFF;
      step(1);
      check_output("en0_gs", 8'(gs), 8'h1);
      check_output("en0_req", 8'(int_req), 8'h0);
      step(3);
      check_output("en0_req_later", 8'(int_req), 8'h0);
      en = 1'b1;
      step(1);
      check_output("en1_req", 8'(int_req), 8'h1);
      check_output("en1_vec", 8'(int_vec), 8'h1);

      // Protocol violations around the channel 1 request.
      pulse_eoi();
      check_output("eoi_in_req_req", 8'(int_req), 8'h1);
      check_output("eoi_in_req_busy", 8'(busy), 8'h0);
      int_ack = 1'b1;
      eoi     = 1'b1;
      step(1);
      int_ack = 1'b0;
      eoi     = 1'b0;
      check_output("ack_eoi_busy", 8'(busy), 8'h1);
      check_output("ack_eoi_req", 8'(int_req), 8'h0);
      pulse_ack();
      step(1);
      check_output("ack_in_svc_busy", 8'(busy), 8'h1);
      check_output("ack_in_svc_req", 8'(int_req), 8'h0);
      pulse_eoi();
      pulse_eoi();
      check_output("eoi_idle_req", 8'(int_req), 8'h0);
      check_output("eoi_idle_busy", 8'(busy), 8'h0);
      pulse_ack();
      step(1);
      check_output("ack_idle_req", 8'(int_req), 8'h0);
      check_output("ack_idle_busy", 8'(busy), 8'h0);

      // New edge on channel 4 in the same cycle as its acknowledge.
      irq_n[4] = 1'b0;
      step(1);
      irq_n[4] = 1'b1;
      step(1);
      check_output("coll_vec", 8'(int_vec), 8'h4);
      irq_n[4] = 1'b0;
      int_ack  = 1'b1;
      step(1);
      int_ack  = 1'b0;
      irq_n[4] = 1'b1;
      check_output("coll_busy", 8'(busy), 8'h1);
      step(1);
      check_output("coll_gs_kept", 8'(gs), 8'h1);
      pulse_eoi();
      step(1);
      check_output("coll_rereq", 8'(int_req), 8'h1);
      check_output("coll_revec", 8'(int_vec), 8'h4);
      pulse_ack();
      pulse_eoi();
      step(1);

      // Reset in SERVICE with channels 1 and 7 pending.
      irq_n = ~8'h82;
      step(1);
      irq_n = 8'hFF;
      step(1);
      check_output("pre_rst_vec", 8'(int_vec), 8'h7);
      pulse_ack();
      irq_n[7] = 1'b0;
      step(1);
      irq_n = 8'hFF;
      step(1);
      check_output("pre_rst_busy", 8'(busy), 8'h1);
      check_output("pre_rst_gs", 8'(gs), 8'h1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_output("mid_rst_req", 8'(int_req), 8'h0);
      check_output("mid_rst_busy", 8'(busy), 8'h0);
      check_output("mid_rst_gs", 8'(gs), 8'h0);
      check_output("mid_rst_vec", 8'(int_vec), 8'h0);
      step(3);
      check_output("post_rst_lost_req", 8'(int_req), 8'h0);
      check_output("post_rst_lost_gs", 8'(gs), 8'h0);

      // Channel 2 held low through reset; level mode keeps re-requesting it.
      irq_n = 8'hFB;
      rst   = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      check_output("lvl_req", 8'(lvl_int_req), 8'h1);
      check_output("lvl_vec", 8'(lvl_int_vec), 8'h2);
      pulse_ack();
      check_output("lvl_busy", 8'(lvl_busy), 8'h1);
      pulse_eoi();
      step(1);
      check_output("lvl_rereq", 8'(lvl_int_req), 8'h1);
      check_output("lvl_revec", 8'(lvl_int_vec), 8'h2);
      check_output("edge_no_rereq", 8'(int_req), 8'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
